// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: data-hazard scoreboard and branch fetch-hold controller
// for a 5-stage pipeline (IF, ID, EX, MEM, WB).
//
// Ports:
//   clk                        pipeline clock, rising edge
//   reset                      synchronous active-high clear
//   id_valid                   ID holds a real instruction
//   id_rs, id_rt               ID source register numbers
//   id_rs_used, id_rt_used     corresponding source is read
//   id_regwr, id_rw            ID instruction writes register id_rw
//   id_branch                  ID instruction is beq/bne/bgtz
//   if_stall                   hold PC and IF/ID
//   id_stall                   hold the ID instruction (data hazard)
//   ex_bubble                  load a NOP into ID/EX
//   pending                    per-register outstanding-write flags
module hazard_scoreboard #(
    parameter int unsigned NREG     = 32,
    parameter int unsigned WB_DIST  = 3,
    parameter int unsigned BR_DELAY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic            id_regwr,
    input  logic [4:0]      id_rw,
    input  logic            id_branch,
    output logic            if_stall,
    output logic            id_stall,
    output logic            ex_bubble,
    output logic [NREG-1:0] pending
);

    localparam int unsigned CW = $clog2(WB_DIST + 1);
    localparam int unsigned BW = $clog2(BR_DELAY + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    logic [CW-1:0] r_cnt [NREG];
    state_t        r_state;
    state_t        w_state_nxt;
    logic [BW-1:0] r_brcnt;
    logic [BW-1:0] w_brcnt_nxt;

    logic w_rs_hz;
    logic w_rt_hz;
    logic w_id_stall;
    logic w_issue;
    logic w_wr_en;
    logic w_br_issue;

    // Scoreboard view: a register is pending while its countdown is nonzero.
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            pending[i] = (r_cnt[i] != '0);
        end
    end

    // Source reads are checked against the current scoreboard, before this
    // instruction's own write is recorded.
    assign w_rs_hz    = id_rs_used & (id_rs != 5'd0) & pending[id_rs];
    assign w_rt_hz    = id_rt_used & (id_rt != 5'd0) & pending[id_rt];
    assign w_id_stall = ~reset & id_valid & (w_rs_hz | w_rt_hz);
    assign w_issue    = id_valid & ~w_id_stall & ~reset;
    assign w_wr_en    = w_issue & id_regwr & (id_rw != 5'd0);
    assign w_br_issue = w_issue & id_branch;

    assign id_stall  = w_id_stall;
    assign ex_bubble = w_id_stall;
    assign if_stall  = ~reset & (w_id_stall | (id_valid & id_branch) |
                                 (r_state == S_HOLD));

    // Countdown per register; a new issue reloads, overriding the decrement.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREG; i++) begin
            if (reset || i == 0) begin
                r_cnt[i] <= '0;
            end else if (w_wr_en && id_rw == 5'(i)) begin
                r_cnt[i] <= CW'(WB_DIST);
            end else if (r_cnt[i] != '0) begin
                r_cnt[i] <= r_cnt[i] - CW'(1);
            end
        end
    end

    // Branch FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_brcnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_brcnt <= w_brcnt_nxt;
        end
    end

    // Branch FSM next state; a branch issuing always (re)starts the hold.
    always_comb begin
        w_state_nxt = r_state;
        w_brcnt_nxt = r_brcnt;
        case (r_state)
            S_IDLE: begin
                if (w_br_issue) begin
                    w_state_nxt = S_HOLD;
                    w_brcnt_nxt = BW'(BR_DELAY);
                end
            end
            S_HOLD: begin
                if (w_br_issue) begin
                    w_state_nxt = S_HOLD;
                    w_brcnt_nxt = BW'(BR_DELAY);
                end else if (r_brcnt == BW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_brcnt_nxt = '0;
                end else begin
                    w_brcnt_nxt = r_brcnt - BW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_brcnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed-vector bench for hazard_scoreboard with
// hand-computed expectations (WB_DIST=3, BR_DELAY=2).
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic        id_regwr;
    logic [4:0]  id_rw;
    logic        id_branch;
    logic        if_stall;
    logic        id_stall;
    logic        ex_bubble;
    logic [31:0] pending;

    int unsigned err_cnt;
    int unsigned chk_cnt;

    hazard_scoreboard #(
        .NREG    (32),
        .WB_DIST (3),
        .BR_DELAY(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_rs_used(id_rs_used),
        .id_rt_used(id_rt_used),
        .id_regwr  (id_regwr),
        .id_rw     (id_rw),
        .id_branch (id_branch),
        .if_stall  (if_stall),
        .id_stall  (id_stall),
        .ex_bubble (ex_bubble),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and,
    // after a further #1, outputs are checked mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic rsu,
                          input logic [4:0] rt, input logic rtu, input logic wr,
                          input logic [4:0] rw, input logic br);
        id_valid   = v;
        id_rs      = rs;
        id_rs_used = rsu;
        id_rt      = rt;
        id_rt_used = rtu;
        id_regwr   = wr;
        id_rw      = rw;
        id_branch  = br;
        #1;
    endtask

    task automatic bubble();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic chk_stall(input string tag, input logic ifs, input logic ids);
        chk({tag, ".if_stall"}, 32'(if_stall), 32'(ifs));
        chk({tag, ".id_stall"}, 32'(id_stall), 32'(ids));
        chk({tag, ".ex_bubble"}, 32'(ex_bubble), 32'(ids));
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        reset   = 1'b1;
        bubble();
        step();
        // reset held with a branch in ID: stalls forced low
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        chk_stall("rst_force", 1'b0, 1'b0);
        chk("rst_pending", pending, 32'h0);
        step();
        reset = 1'b0;
        bubble();
        chk("rst_idle_if", 32'(if_stall), 32'h0);

        // Test 1: add rw=5 issues at edge 0; reader of r5 stalls cycles 1-3
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0);
        chk_stall("t1.c0", 1'b0, 1'b0);
        step();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            chk_stall($sformatf("t1.c%0d", c), 1'b1, 1'b1);
            chk($sformatf("t1.c%0d.pend5", c), 32'(pending[5]), 32'h1);
            step();
        end
        chk_stall("t1.c4", 1'b0, 1'b0);
        chk("t1.c4.pend", pending, 32'h0);
        step();
        bubble();

        // Test 2: write to r0 is ignored; reads of r0 never stall
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("t2.pend", pending, 32'h0);
        chk_stall("t2.rd", 1'b0, 1'b0);
        step();
        chk("t2.pend2", pending, 32'h0);
        bubble();

        // Test 3: beq issues at edge 0; fetch held through cycle 2
        set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b1);
        chk_stall("t3.c0", 1'b1, 1'b0);
        step();
        bubble();
        chk_stall("t3.c1", 1'b1, 1'b0);
        step();
        chk_stall("t3.c2", 1'b1, 1'b0);
        step();
        chk_stall("t3.c3", 1'b0, 1'b0);

        // Test 4: r7 written at edges 0 and 1; rt reader stalls cycles 2-4
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
        step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
        step();
        set_id(1'b1, 5'd1, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            chk_stall($sformatf("t4.c%0d", c), 1'b1, 1'b1);
            step();
        end
        chk_stall("t4.c5", 1'b0, 1'b0);
        chk("t4.c5.pend", pending, 32'h0);
        step();
        bubble();

        // Test 5: bne on pending r9 (counter 2); stall 2 cycles then hold 2
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
        step();
        bubble();
        chk("t5.c1.pend", pending, 32'h0000_0200);
        step();
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        chk_stall("t5.c2", 1'b1, 1'b1);
        step();
        chk_stall("t5.c3", 1'b1, 1'b1);
        step();
        chk_stall("t5.c4", 1'b1, 1'b0);
        step();
        bubble();
        chk_stall("t5.c5", 1'b1, 1'b0);
        step();
        chk_stall("t5.c6", 1'b1, 1'b0);
        step();
        chk_stall("t5.c7", 1'b0, 1'b0);

        // Test 6: source equals destination: checked against old state
        set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0);
        chk_stall("t6.self", 1'b0, 1'b0);
        step();
        bubble();
        chk("t6.pend12", pending, 32'h0000_1000);
        // a bubble naming a pending source does not stall
        set_id(1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        chk_stall("t6.bubble", 1'b0, 1'b0);
        step();
        step();
        step();
        bubble();
        chk("t6.drain", pending, 32'h0);

        // Test 7: reset with r9/r10 pending and FSM in HOLD
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
        step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 1'b1);
        step();
        bubble();
        chk("t7.pend", pending, 32'h0000_0600);
        chk_stall("t7.hold", 1'b1, 1'b0);
        reset = 1'b1;
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        chk_stall("t7.inrst", 1'b0, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("t7.pend_clr", pending, 32'h0);
        chk_stall("t7.after", 1'b0, 1'b0);
        step();
        bubble();
        chk("t7.end", pending, 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Sequential hazard controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It tracks in-flight register writes in a per-register countdown scoreboard and holds the decode stage while any source operand is still pending. It sequences fetch holds after branches (beq/bne/bgtz) through a small state machine. It drives the IF/ID hold and ID/EX bubble controls.

## Interface
- `NREG`, 32: number of architectural registers; register 0 is hard-wired zero.
- `WB_DIST`, 3: cycles from ID issue until the destination value is readable from the register file; legal range 1..7.
- `BR_DELAY`, 2: cycles fetch stays held after a branch issues from ID; legal range 1..7.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `id_valid`  in  1  ID holds a real instruction (0 = bubble).
- `id_rs`, `id_rt`  in  5 each  ID source register numbers.
- `id_rs_used`, `id_rt_used`  in  1 each  the corresponding source is actually read.
- `id_regwr`  in  1  the ID instruction writes a register.
- `id_rw`  in  5  ID destination register number.
- `id_branch`  in  1  the ID instruction is beq/bne/bgtz.
- `if_stall`  out  1  hold PC and the IF/ID register.
- `id_stall`  out  1  hold the ID instruction (data hazard).
- `ex_bubble`  out  1  load a NOP into ID/EX this cycle.
- `pending`  out  NREG  bit r = 1 while register r has an outstanding write (debug/verification).

## Operation
- Scoreboard: each register has one counter of width ceil(log2(WB_DIST+1)). `pending[r]` = (cnt[r] != 0). cnt[0] is constant 0.
- Issue condition: `issue = id_valid & ~id_stall & ~reset`.
- On issue with `id_regwr` and `id_rw != 0`, set cnt[id_rw] to WB_DIST. This overrides any decrement of the same entry in the same cycle.
- Every other nonzero counter decrements by 1 each cycle. Counters saturate at 0.
- Data hazard: `id_stall = id_valid & ((id_rs_used & id_rs!=0 & pending[id_rs]) | (id_rt_used & id_rt!=0 & pending[id_rt]))`.
- The register file has no write-through. A value is readable only in the cycle after its counter reaches 0.
- `ex_bubble = id_stall`. A stalled instruction never updates the scoreboard or the FSM.
- Branch FSM states:
  - IDLE: on issue with `id_branch`, go to HOLD and set brcnt to BR_DELAY.
  - HOLD: brcnt decrements each cycle. On the edge where brcnt==1, return to IDLE.
  - A branch issuing on the same edge HOLD exits goes back to HOLD. This cannot occur while fetch is held, but the behaviour is defined for robustness.
- `if_stall = id_stall | (id_valid & id_branch) | (state==HOLD)`.
- A branch blocked by a data hazard keeps `if_stall` high through `id_stall`. The FSM stays IDLE until the branch issues.
- All outputs are combinational from registered state and ID inputs, with no input-to-state combinational loop through `id_stall`.

## Timing
- Reset: on the first edge with reset=1, all counters clear to 0, the state goes to IDLE and brcnt to 0.
  - While reset=1, `if_stall`, `id_stall` and `ex_bubble` are forced to 0, and `pending` is 0 after that edge.
  - Reset mid-operation discards all outstanding writes and any branch hold.
- Write issued at edge T: `pending` is high for cycles T+1..T+WB_DIST. A dependent instruction in ID at T+1 stalls exactly WB_DIST cycles and issues at edge T+WB_DIST+1.
- Branch issued at edge T: `if_stall` is high in the issue cycle (T-1..T) and for BR_DELAY cycles after T, then drops.
- Back-to-back writes to the same register: the latest issue reloads the counter. Pending time is measured from the last write.
- When a source equals a destination in the same instruction, the read is checked against the old scoreboard state, then the counter is set.

## Test plan
- Defaults; issue `add` rw=5 at edge 0, then ID holds rs=5 (used) from cycle 1 -> `id_stall`=`ex_bubble`=`if_stall`=1 for cycles 1-3, 0 at cycle 4; `pending[5]` high cycles 1-3.
- Issue write rw=0, then read rs=0 and rt=0 -> `pending`=0, no stall at any cycle.
- Issue beq (no hazard) at edge 0 -> `if_stall`=1 in the issue cycle and in cycles 1-2, 0 at cycle 3; `id_stall` stays 0.
- Writes to r7 at edges 0 and 1, reader of r7 (rt) at cycle 2 -> stall through cycle 4, issue at edge 5.
- bne with rs=9 pending (counter 2) -> `id_stall` for 2 cycles with FSM IDLE; then issue, HOLD for 2 cycles; `if_stall` continuous for 4+ cycles.
- r9 and r10 pending with FSM in HOLD, assert reset one cycle -> next cycle `pending`=0, FSM IDLE, reader of r9 issues without stall.
